// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - load/store unit: big-endian byte lanes, single outstanding bus access with timeout.
// Optional LSU_MISALIGN_EXC_EN reports misaligned H/W/D accesses instead of aligning them.
module mem_lsu #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  input  logic [4:0]        mem_op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] st_data_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              out_valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [1:0]        exc_o,
  output logic [ADDR_W-1:0] badaddr_o
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_WAIT   = 1'b1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [0:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [NB-1:0]     bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]        ld_lo_q, ld_lo_d, ld_nb_q, ld_nb_d;
  logic              ld_uns_q, ld_uns_d, is_st_q, is_st_d, kill_q, kill_d;
  logic [4:0]        op_wd_q, op_wd_d, wd_q, wd_d;
  logic              op_wreg_q, op_wreg_d, wreg_q, wreg_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        exc_q, exc_d;
  logic [ADDR_W-1:0] badaddr_q, badaddr_d;

  logic [1:0]        size_eff;
  logic [3:0]        nbytes, lane_lo;
  logic [OFF_W-1:0]  off_raw, low_m, off_al;
  logic [15:0]       sel16;
  logic [DATA_W-1:0] st_rep, ld_shift, ld_mask, ld_top, ld_val;
  logic              ld_neg;

  // Request decode; lane_lo is the bus_sel bit index of the last (least significant) byte.
  always_comb begin
    size_eff = (DATA_W == 32 && mem_op_i[1:0] == 2'd3) ? 2'd2 : mem_op_i[1:0];
    nbytes   = 4'd1 << size_eff;
    off_raw  = addr_i[OFF_W-1:0];
    low_m    = OFF_W'(nbytes - 4'd1);
    off_al   = off_raw & ~low_m;
    lane_lo  = 4'(NB) - 4'(off_al) - nbytes;
    sel16    = ((16'd1 << nbytes) - 16'd1) << lane_lo;
    case (size_eff)
      2'd0:    st_rep = {NB{st_data_i[7:0]}};
      2'd1:    st_rep = {(NB/2){st_data_i[15:0]}};
      2'd2:    st_rep = {(NB/4){st_data_i[31:0]}};
      default: st_rep = st_data_i;
    endcase
  end

  // Load return path: right-justify the selected lanes, then extend from the top selected bit.
  always_comb begin
    ld_shift = bus_rdata_i >> {ld_lo_q, 3'b000};
    ld_mask  = ~({DATA_W{1'b1}} << {ld_nb_q, 3'b000});
    ld_top   = ld_mask & ~(ld_mask >> 1);
    ld_neg   = ~ld_uns_q & (|(ld_shift & ld_top));
    ld_val   = (ld_shift & ld_mask) | (ld_neg ? ~ld_mask : '0);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_sel_d   = bus_sel_q;
    bus_wdata_d = bus_wdata_q;
    ld_lo_d     = ld_lo_q;
    ld_nb_d     = ld_nb_q;
    ld_uns_d    = ld_uns_q;
    is_st_d     = is_st_q;
    kill_d      = kill_q;
    op_wd_d     = op_wd_q;
    op_wreg_d   = op_wreg_q;
    out_valid_d = 1'b0;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    exc_d       = exc_q;
    badaddr_d   = badaddr_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i && !flush_i) begin
          if (!mem_op_i[4]) begin
            out_valid_d = 1'b1;
            wd_d        = wd_i;
            wreg_d      = wreg_i;
            wdata_d     = wdata_i;
            exc_d       = 2'b00;
            badaddr_d   = '0;
          end
`ifdef LSU_MISALIGN_EXC_EN
          else if (|(off_raw & low_m)) begin
            out_valid_d = 1'b1;
            wd_d        = wd_i;
            wreg_d      = 1'b0;
            wdata_d     = '0;
            exc_d       = mem_op_i[3] ? 2'b10 : 2'b01;
            badaddr_d   = addr_i;
          end
`endif
          else begin
            state_d     = S_WAIT;
            cnt_d       = '0;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_op_i[3];
            bus_addr_d  = {addr_i[ADDR_W-1:OFF_W], off_al};
            bus_sel_d   = sel16[NB-1:0];
            bus_wdata_d = mem_op_i[3] ? st_rep : '0;
            ld_lo_d     = lane_lo;
            ld_nb_d     = nbytes;
            ld_uns_d    = mem_op_i[2];
            is_st_d     = mem_op_i[3];
            op_wd_d     = wd_i;
            op_wreg_d   = wreg_i;
            kill_d      = 1'b0;
          end
        end
      end
      S_WAIT: begin
        kill_d = kill_q | flush_i;
        // Ack is tested first so it wins over a counter expiring on the same edge.
        if (bus_ack_i || cnt_q == CNT_LAST) begin
          state_d     = S_IDLE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          out_valid_d = ~(kill_q | flush_i);
          wd_d        = op_wd_q;
          if (bus_ack_i) begin
            wreg_d    = op_wreg_q & ~is_st_q;
            wdata_d   = is_st_q ? '0 : ld_val;
            exc_d     = 2'b00;
            badaddr_d = '0;
          end else begin
            wreg_d    = 1'b0;
            wdata_d   = '0;
            exc_d     = 2'b11;
            badaddr_d = bus_addr_q;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      ld_lo_q     <= '0;
      ld_nb_q     <= '0;
      ld_uns_q    <= 1'b0;
      is_st_q     <= 1'b0;
      kill_q      <= 1'b0;
      op_wd_q     <= '0;
      op_wreg_q   <= 1'b0;
      out_valid_q <= 1'b0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      wdata_q     <= '0;
      exc_q       <= 2'b00;
      badaddr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_sel_q   <= bus_sel_d;
      bus_wdata_q <= bus_wdata_d;
      ld_lo_q     <= ld_lo_d;
      ld_nb_q     <= ld_nb_d;
      ld_uns_q    <= ld_uns_d;
      is_st_q     <= is_st_d;
      kill_q      <= kill_d;
      op_wd_q     <= op_wd_d;
      op_wreg_q   <= op_wreg_d;
      out_valid_q <= out_valid_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      exc_q       <= exc_d;
      badaddr_q   <= badaddr_d;
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign wd_o        = wd_q;
  assign wreg_o      = wreg_q;
  assign wdata_o     = wdata_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;
  assign exc_o       = exc_q;
  assign badaddr_o   = badaddr_q;
endmodule
